// File: rtl/seg_dec_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Segment patterns are active-low, packed {ca,cb,cc,cd,ce,cf,cg}.
package seg_dec_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } seg_result_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to BCD lookup.
// Define SEG_HEX_DECODE_EN to also accept the A-F glyphs as values 10..15.
module seg_pattern_decode
  import seg_dec_pkg::*;
(
  input  logic [6:0]  i_seg,
  output seg_result_t o_result
);

  always_comb begin
    o_result = '0;
    case (i_seg)
      SEG_0:     o_result = {1'b1, 1'b0, 4'd0};
      SEG_1:     o_result = {1'b1, 1'b0, 4'd1};
      SEG_2:     o_result = {1'b1, 1'b0, 4'd2};
      SEG_3:     o_result = {1'b1, 1'b0, 4'd3};
      SEG_4:     o_result = {1'b1, 1'b0, 4'd4};
      SEG_5:     o_result = {1'b1, 1'b0, 4'd5};
      SEG_6:     o_result = {1'b1, 1'b0, 4'd6};
      SEG_7:     o_result = {1'b1, 1'b0, 4'd7};
      SEG_8:     o_result = {1'b1, 1'b0, 4'd8};
      SEG_9:     o_result = {1'b1, 1'b0, 4'd9};
`ifdef SEG_HEX_DECODE_EN
      SEG_A:     o_result = {1'b1, 1'b0, 4'd10};
      SEG_B:     o_result = {1'b1, 1'b0, 4'd11};
      SEG_C:     o_result = {1'b1, 1'b0, 4'd12};
      SEG_D:     o_result = {1'b1, 1'b0, 4'd13};
      SEG_E:     o_result = {1'b1, 1'b0, 4'd14};
      SEG_F:     o_result = {1'b1, 1'b0, 4'd15};
`endif
      SEG_BLANK: o_result = {1'b0, 1'b1, 4'd0};
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit BCD values from a multiplexed active-low 7-segment bus.
// Build option: SEG_HEX_DECODE_EN (handled inside seg_pattern_decode).
//
// Handshake: there is no valid/ready flow control. update is a one-cycle
// strobe qualifying upd_idx; digit_* are level outputs that change only on
// the cycle update is high (or on reset).
module seg_scan_decoder
  import seg_dec_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic [2:0]              upd_idx,
  output logic                    err_pattern,
  output logic                    err_collision,
  output scan_state_e             dbg_state
);

  logic [NUM_DIGITS-1:0] r_an, r_trk_an;
  logic [6:0]            r_seg, r_trk_seg;
  scan_state_e           r_state, w_state_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic                  w_single, w_multi, w_same, w_load, w_commit;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [2:0]            w_idx;
  seg_result_t           w_res;

  logic [3:0]            r_bcd [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_valid, r_blank;
  logic                  r_update, r_err_pattern, r_err_collision;
  logic [2:0]            r_upd_idx;

  assign w_sel    = ~r_an;
  assign w_single = ($countones(w_sel) == 1);
  assign w_multi  = ($countones(w_sel) > 1);
  assign w_same   = (r_an == r_trk_an) && (r_seg == r_trk_seg);

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel[i]) w_idx = 3'(i);
    end
  end

  seg_pattern_decode u_decode (
    .i_seg    (r_seg),
    .o_result (w_res)
  );

  // r_trk_* holds the sample being counted; a match against the current
  // sample means "unchanged since the previous cycle".
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_single) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = 8'd1;
          w_load      = 1'b1;
        end
      end
      ST_TRACK: begin
        if (w_single && w_same) begin
          if (r_cnt == 8'(STABLE_CYCLES - 1)) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_LOCKED;
          end
          w_cnt_nxt = r_cnt + 8'd1;
        end else if (w_single) begin
          w_cnt_nxt = 8'd1;
          w_load    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_LOCKED: begin
        if (w_single && w_same) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_single) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = 8'd1;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Sample registers reset to "no digit selected" so reset never reads as a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an      <= '1;
      r_seg     <= SEG_BLANK;
      r_trk_an  <= '1;
      r_trk_seg <= SEG_BLANK;
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
    end else begin
      r_an    <= an;
      r_seg   <= seg;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_trk_an  <= r_an;
        r_trk_seg <= r_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_update        <= 1'b0;
      r_upd_idx       <= 3'd0;
      r_err_pattern   <= 1'b0;
      r_err_collision <= 1'b0;
      r_valid         <= '0;
      r_blank         <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_bcd[i] <= 4'd0;
    end else begin
      r_update        <= w_commit;
      r_err_pattern   <= w_commit && !w_res.legal && !w_res.blank;
      r_err_collision <= w_multi;
      if (w_commit) r_upd_idx <= w_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_commit && w_sel[i]) begin
          if (w_res.legal) begin
            r_bcd[i]   <= w_res.value;
            r_valid[i] <= 1'b1;
            r_blank[i] <= 1'b0;
          end else begin
            r_valid[i] <= 1'b0;
            r_blank[i] <= w_res.blank;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
    assign digit_bcd[4*g +: 4] = r_bcd[g];
  end

  assign digit_valid   = r_valid;
  assign digit_blank   = r_blank;
  assign update        = r_update;
  assign upd_idx       = r_upd_idx;
  assign err_pattern   = r_err_pattern;
  assign err_collision = r_err_collision;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus randomized holds,
// checked cycle by cycle against a run-length reference model.
module tb_seg_scan_decoder;
  import seg_dec_pkg::*;

  localparam int ND = 4;
  localparam int S  = 4;
`ifdef SEG_HEX_DECODE_EN
  localparam int NLEGAL = 16;
`else
  localparam int NLEGAL = 10;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ND-1:0]     an;
  logic [6:0]        seg;
  logic [4*ND-1:0]   digit_bcd;
  logic [ND-1:0]     digit_valid, digit_blank;
  logic              update, err_pattern, err_collision;
  logic [2:0]        upd_idx;
  scan_state_e       dbg_state;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .an            (an),
    .seg           (seg),
    .digit_bcd     (digit_bcd),
    .digit_valid   (digit_valid),
    .digit_blank   (digit_blank),
    .update        (update),
    .upd_idx       (upd_idx),
    .err_pattern   (err_pattern),
    .err_collision (err_collision),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int vectors = 0;
  int errors  = 0;
  // entry: {commit, collision, an[3:0], seg[6:0]} for the sample captured last edge
  logic [12:0] exp_q[$];
  int          m_bcd   [ND];
  bit          m_valid [ND];
  bit          m_blank [ND];
  logic [10:0] prev_x;
  int          run;
  int          n_upd, n_coll, n_errp;
  logic [6:0]  pat_tab [16];

  function automatic int model_decode(input logic [6:0] s);
    int r;
    r = -1;
    if (s == 7'b1111111) return 16;
    for (int v = 0; v < NLEGAL; v++) if (pat_tab[v] == s) r = v;
    return r;
  endfunction

  function automatic logic [4*ND-1:0] model_bcd_word();
    logic [4*ND-1:0] w;
    w = '0;
    for (int i = 0; i < ND; i++) w[4*i +: 4] = 4'(m_bcd[i]);
    return w;
  endfunction

  function automatic logic [ND-1:0] model_valid_word();
    logic [ND-1:0] w;
    for (int i = 0; i < ND; i++) w[i] = m_valid[i];
    return w;
  endfunction

  function automatic logic [ND-1:0] model_blank_word();
    logic [ND-1:0] w;
    for (int i = 0; i < ND; i++) w[i] = m_blank[i];
    return w;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < ND; i++) begin
      m_bcd[i] = 0; m_valid[i] = 1'b0; m_blank[i] = 1'b0;
    end
    prev_x = '1;
    run    = 0;
  endtask

  // ---------------- driver: one clock of stimulus + scoreboard step ----------------
  task automatic drive(input logic [ND-1:0] a, input logic [6:0] s);
    logic [12:0] e;
    bit          commit, coll, exp_errp;
    int          idx, d, nlow;
    an  = a;
    seg = s;
    @(posedge clk);
    #1;
    e        = (exp_q.size() > 0) ? exp_q.pop_front() : 13'd0;
    commit   = e[12];
    coll     = e[11];
    idx      = 0;
    for (int i = 0; i < ND; i++) if (!e[7+i]) idx = i;
    d        = model_decode(e[6:0]);
    exp_errp = commit && (d < 0);
    if (commit) begin
      if (d >= 0 && d < 16) begin
        m_bcd[idx] = d; m_valid[idx] = 1'b1; m_blank[idx] = 1'b0;
      end else begin
        m_valid[idx] = 1'b0; m_blank[idx] = (d == 16);
      end
    end
    n_upd  += int'(update);
    n_coll += int'(err_collision);
    n_errp += int'(err_pattern);

    vectors++;
    if (update !== commit) begin
      errors++; $display("FAIL update: got %0b expected %0b at %0t", update, commit, $time);
    end
    vectors++;
    if (err_pattern !== exp_errp) begin
      errors++; $display("FAIL err_pattern: got %0b expected %0b at %0t", err_pattern, exp_errp, $time);
    end
    vectors++;
    if (err_collision !== coll) begin
      errors++; $display("FAIL err_collision: got %0b expected %0b at %0t", err_collision, coll, $time);
    end
    if (commit) begin
      vectors++;
      if (upd_idx !== 3'(idx)) begin
        errors++; $display("FAIL upd_idx: got %0d expected %0d at %0t", upd_idx, idx, $time);
      end
    end
    vectors++;
    if (digit_bcd !== model_bcd_word()) begin
      errors++; $display("FAIL digit_bcd: got %h expected %h at %0t", digit_bcd, model_bcd_word(), $time);
    end
    vectors++;
    if (digit_valid !== model_valid_word()) begin
      errors++; $display("FAIL digit_valid: got %b expected %b at %0t", digit_valid, model_valid_word(), $time);
    end
    vectors++;
    if (digit_blank !== model_blank_word()) begin
      errors++; $display("FAIL digit_blank: got %b expected %b at %0t", digit_blank, model_blank_word(), $time);
    end

    // model the sample just captured: commit when a single-anode run reaches S
    nlow = $countones(~a);
    if (nlow == 1) run = ({a, s} == prev_x && run > 0) ? run + 1 : 1;
    else           run = 0;
    prev_x = {a, s};
    exp_q.push_back({(run == S), (nlow > 1), a, s});
  endtask

  task automatic clear_counts();
    n_upd = 0; n_coll = 0; n_errp = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    an  = '1;
    seg = 7'b1111111;
    @(posedge clk);
    #1;
    model_clear();
    vectors++;
    if (digit_bcd !== '0) begin errors++; $display("FAIL reset_bcd: got %h expected 0", digit_bcd); end
    vectors++;
    if (digit_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b expected 0", digit_valid); end
    vectors++;
    if (digit_blank !== '0) begin errors++; $display("FAIL reset_blank: got %b expected 0", digit_blank); end
    vectors++;
    if ({update, err_pattern, err_collision} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {update, err_pattern, err_collision});
    end
    vectors++;
    if (upd_idx !== 3'd0) begin errors++; $display("FAIL reset_upd_idx: got %0d expected 0", upd_idx); end
    vectors++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_single_commit();
    clear_counts();
    for (int c = 0; c < 6; c++) drive(4'b1110, 7'b0010010);
    vectors++;
    if (n_upd != 1) begin errors++; $display("FAIL single_update_count: got %0d expected 1", n_upd); end
    vectors++;
    if (digit_bcd[3:0] !== 4'd2) begin errors++; $display("FAIL single_bcd: got %0d expected 2", digit_bcd[3:0]); end
    vectors++;
    if (digit_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b expected 0001", digit_valid); end
  endtask

  task automatic test_round_robin();
    int vals [4];
    vals[0] = 9; vals[1] = 4; vals[2] = 0; vals[3] = 7;
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) drive(~(4'b0001 << (3 - k)), pat_tab[vals[k]]);
    end
    vectors++;
    if (n_upd != 4) begin errors++; $display("FAIL rr_update_count: got %0d expected 4", n_upd); end
    vectors++;
    if (digit_bcd !== 16'h9407) begin errors++; $display("FAIL rr_bcd: got %h expected 9407", digit_bcd); end
    vectors++;
    if (digit_valid !== 4'b1111) begin errors++; $display("FAIL rr_valid: got %b expected 1111", digit_valid); end
  endtask

  task automatic test_glitch();
    clear_counts();
    for (int c = 0; c < 3; c++) drive(4'b1101, 7'b0000000);
    for (int c = 0; c < 6; c++) drive(4'b1101, 7'b0000110);
    vectors++;
    if (n_upd != 1) begin errors++; $display("FAIL glitch_update_count: got %0d expected 1", n_upd); end
    vectors++;
    if (digit_bcd !== 16'h9437) begin errors++; $display("FAIL glitch_bcd: got %h expected 9437", digit_bcd); end
  endtask

  task automatic test_collision();
    clear_counts();
    drive(4'b1100, 7'b0000000);
    drive(4'b1100, 7'b0000000);
    drive(4'b1111, 7'b1111111);
    drive(4'b1111, 7'b1111111);
    vectors++;
    if (n_coll != 2) begin errors++; $display("FAIL coll_count: got %0d expected 2", n_coll); end
    vectors++;
    if (n_upd != 0) begin errors++; $display("FAIL coll_update_count: got %0d expected 0", n_upd); end
    vectors++;
    if (digit_bcd !== 16'h9437) begin errors++; $display("FAIL coll_bcd: got %h expected 9437", digit_bcd); end
  endtask

  task automatic test_hex_pattern();
    clear_counts();
    for (int c = 0; c < 6; c++) drive(4'b0111, 7'b0001000);
`ifdef SEG_HEX_DECODE_EN
    vectors++;
    if (digit_bcd[15:12] !== 4'hA) begin errors++; $display("FAIL hex_bcd: got %h expected a", digit_bcd[15:12]); end
    vectors++;
    if (digit_valid[3] !== 1'b1) begin errors++; $display("FAIL hex_valid: got %b expected 1", digit_valid[3]); end
`else
    vectors++;
    if (n_errp != 1) begin errors++; $display("FAIL hex_err_count: got %0d expected 1", n_errp); end
    vectors++;
    if (digit_valid[3] !== 1'b0) begin errors++; $display("FAIL hex_valid: got %b expected 0", digit_valid[3]); end
`endif
  endtask

  task automatic test_blank_reset();
    for (int c = 0; c < 6; c++) drive(4'b1011, 7'b1111111);
    vectors++;
    if (digit_blank !== 4'b0100) begin errors++; $display("FAIL blank_mask: got %b expected 0100", digit_blank); end
    vectors++;
    if (digit_valid[2] !== 1'b0) begin errors++; $display("FAIL blank_valid: got %b expected 0", digit_valid[2]); end
    drive(4'b1110, 7'b0100100);
    drive(4'b1110, 7'b0100100);
    test_reset();
  endtask

  task automatic test_random();
    logic [ND-1:0] a;
    logic [6:0]    s;
    int            sel, hold;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = ~(4'b0001 << $urandom_range(0, ND - 1));
      else if (sel < 8) a = '1;
      else              a = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
      if (sel < 7)      s = pat_tab[$urandom_range(0, 15)];
      else if (sel < 8) s = 7'b1111111;
      else              s = 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) drive(a, s);
    end
    drive(4'b1111, 7'b1111111);
  endtask

  // ---------------- main sequence + final report ----------------
  initial begin
    pat_tab[0]  = 7'b0000001; pat_tab[1]  = 7'b1001111; pat_tab[2]  = 7'b0010010;
    pat_tab[3]  = 7'b0000110; pat_tab[4]  = 7'b1001100; pat_tab[5]  = 7'b0100100;
    pat_tab[6]  = 7'b0100000; pat_tab[7]  = 7'b0001111; pat_tab[8]  = 7'b0000000;
    pat_tab[9]  = 7'b0000100; pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b1100000;
    pat_tab[12] = 7'b0110001; pat_tab[13] = 7'b1000010; pat_tab[14] = 7'b0110000;
    pat_tab[15] = 7'b0111000;
    rst = 1'b1;
    an  = '1;
    seg = 7'b1111111;
    @(posedge clk);
    test_reset();
    test_single_commit();
    test_round_robin();
    test_glitch();
    test_collision();
    test_hex_pattern();
    test_blank_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the team's BCD-to-seven-segment encoder.
- Monitors the anode strobes and active-low cathode lines of a time-multiplexed 4-digit display.
- Recovers the BCD value of each digit once its pattern is stable, and flags illegal patterns and anode collisions.
- Sits on the display-bus tap in self-check / loopback builds, feeding a scoreboard or the status register block.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode width); legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit is committed; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- an  input  NUM_DIGITS  active-low digit enables; bit i selects digit i.
- seg  input  7  active-low cathodes packed {ca,cb,cc,cd,ce,cf,cg}; ca is the MSB.
- digit_bcd  output  4*NUM_DIGITS  committed value per digit; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  digit i holds a legally decoded value.
- digit_blank  output  NUM_DIGITS  digit i was last committed as blank (seg = 7'b1111111).
- update  output  1  one-cycle pulse on every commit.
- upd_idx  output  3  index of the committed digit, valid with update.
- err_pattern  output  1  one-cycle pulse when an illegal pattern is committed.
- err_collision  output  1  one-cycle pulse when a sample has more than one anode low.

Behaviour:
- Reset: all outputs 0, digit_bcd all 0, sample registers cleared, FSM in IDLE.
- Input stage: an and seg are registered once per cycle. All decisions use the registered sample.
- Sample classification:
  - none: an all ones.
  - single: exactly one bit low.
  - multi: two or more bits low.
- FSM states:
  - IDLE: entered on reset or on a none/multi sample. Stability count cleared.
  - TRACK: entered on a single sample. Count starts at 1.
    - Same {an,seg} as the previous sample: count +1.
    - Different single sample: stay in TRACK, count restarts at 1.
    - Count reaches STABLE_CYCLES: commit, go to LOCKED.
  - LOCKED: hold while the sample is unchanged; no further commits. On a change, go to TRACK (single) or IDLE (none/multi).
- Latency: if an/seg are constant for STABLE_CYCLES rising edges k..k+S-1, the commit effects (update=1, digit registers updated) are visible in the cycle after edge k+S. Total latency is S+1 edges, counting the input register.
- Commit, using the decode table (active-low, {ca..cg}):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Legal pattern: digit_bcd[idx]=value, valid=1, blank=0.
  - 1111111: blank=1, valid=0, bcd unchanged.
  - Any other pattern: valid=0, blank=0, bcd unchanged, err_pattern pulses with update.
- Collision: err_collision pulses for each multi sample. The FSM goes to IDLE and no commit occurs.
- Glitch rejection: any change before the count completes restarts the count, so short ghosting at digit transitions is never committed.
- Simultaneous events: the commit and a new differing sample on the same edge are both honoured. The commit uses the old sample; tracking restarts with the new one.
- Reset mid-track: the count is discarded and committed digits are cleared.

Optional Feature:
- SEG_HEX_DECODE_EN:
  - Defined: A-F are also legal: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. They commit values 10..15 with valid=1.
  - Undefined: these patterns are illegal and raise err_pattern.

Decomposition:
- Package seg_dec_pkg:
  - SEG_0..SEG_9, SEG_A..SEG_F and SEG_BLANK as 7-bit localparams.
  - A result typedef {legal, blank, value[3:0]}.
- Sub-module seg_pattern_decode: purely combinational pattern-to-result lookup, with the hex entries guarded by the macro.
- seg_scan_decoder keeps the input register, FSM, counter and digit register file.

Test Plan:
- Reset, then an=1110 with seg=0010010 held for 4 cycles -> update pulses once on the 5th edge; upd_idx=0, digit_bcd[3:0]=2, digit_valid=0001.
- Round-robin scan of digits 3..0 showing 9,4,0,7, each held 8 cycles -> digit_bcd=16'h9407, digit_valid=1111, exactly 4 update pulses per scan.
- an=1101 with seg=0000000 held 3 cycles, then 0000110 -> no commit for 8; 3 commits to digit 1 after 4 stable cycles.
- an=1100 for 2 cycles -> err_collision pulses twice, no update, digit registers unchanged.
- an=0111 with seg=0001000 held 4 cycles -> macro off: err_pattern=1, digit_valid[3]=0. Macro on: digit_bcd[15:12]=4'hA, valid=1.
- Blank then reset: seg=1111111 on digit 2 -> digit_blank=0100. Assert rst mid-track on a later digit -> all outputs 0 on the next edge.
